// File: rtl/nonblocking_delay_channel.sv
// Multi-lane fixed-latency message channel with no backpressure, synchronous flush and occupancy outputs.
// Optional delivered-message counter enabled by defining NONBLOCKING_DELAY_CHANNEL_COUNTER_EN.
module nonblocking_delay_channel #(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 1,
    parameter int LATENCY     = 1,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  initialize,
    input  logic [CHANNELS*WIDTH-1:0]             in_data,
    input  logic [CHANNELS-1:0]                   in_valid,
    output logic [CHANNELS*WIDTH-1:0]             out_data,
    output logic [CHANNELS-1:0]                   out_valid,
    output logic                                  busy,
    output logic [$clog2(CHANNELS*LATENCY+1)-1:0] in_flight
`ifdef NONBLOCKING_DELAY_CHANNEL_COUNTER_EN
    ,
    output logic [COUNT_WIDTH-1:0]                delivered_count
`endif
);

    localparam int STAGES = CHANNELS * LATENCY;
    localparam int IFW    = $clog2(STAGES + 1);

    if (WIDTH < 1 || CHANNELS < 1 || LATENCY < 1 || COUNT_WIDTH < 1) begin : g_bad_params
        $error("nonblocking_delay_channel: all parameters must be >= 1");
    end

    // Stage s of lane c lives at flat index c*LATENCY+s; the last stage of each lane is the output.
    logic [STAGES-1:0]       valid_q, valid_d;
    logic [STAGES*WIDTH-1:0] data_q, data_d;
    logic [IFW-1:0]          in_flight_sum;

    always_comb begin
        valid_d = '0;
        data_d  = data_q;
        if (!initialize) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int s = 0; s < LATENCY; s++) begin
                    if (s == 0) begin
                        valid_d[c*LATENCY] = in_valid[c];
                        if (in_valid[c]) begin
                            data_d[(c*LATENCY)*WIDTH +: WIDTH] = in_data[c*WIDTH +: WIDTH];
                        end
                    end else begin
                        valid_d[c*LATENCY+s] = valid_q[c*LATENCY+s-1];
                        if (valid_q[c*LATENCY+s-1]) begin
                            data_d[(c*LATENCY+s)*WIDTH +: WIDTH] =
                                data_q[(c*LATENCY+s-1)*WIDTH +: WIDTH];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane_out
        assign out_valid[g]                = valid_q[g*LATENCY+LATENCY-1];
        assign out_data[g*WIDTH +: WIDTH]  = data_q[(g*LATENCY+LATENCY-1)*WIDTH +: WIDTH];
    end

    always_comb begin
        in_flight_sum = '0;
        for (int i = 0; i < STAGES; i++) begin
            in_flight_sum = in_flight_sum + IFW'(valid_q[i]);
        end
    end

    assign in_flight = in_flight_sum;
    assign busy      = |valid_q;

`ifdef NONBLOCKING_DELAY_CHANNEL_COUNTER_EN
    // Sum is computed one popcount wider than the counter so saturation is detected without wrap.
    localparam int PCW = $clog2(CHANNELS + 1);
    localparam int SW  = COUNT_WIDTH + PCW;
    localparam logic [SW-1:0] SAT = {{PCW{1'b0}}, {COUNT_WIDTH{1'b1}}};

    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [SW-1:0]          count_sum;

    always_comb begin
        count_sum = SW'(count_q);
        for (int c = 0; c < CHANNELS; c++) begin
            count_sum = count_sum + SW'(out_valid[c]);
        end
        if (initialize) begin
            count_d = '0;
        end else if (count_sum > SAT) begin
            count_d = '1;
        end else begin
            count_d = count_sum[COUNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign delivered_count = count_q;
`endif

endmodule

// File: tb/tb_nonblocking_delay_channel.sv
// Scoreboard bench for nonblocking_delay_channel: two lanes, three-stage latency.
// Covers counter saturation when NONBLOCKING_DELAY_CHANNEL_COUNTER_EN is defined.
module tb_nonblocking_delay_channel;

   localparam int WIDTH = 8;
   localparam int CHANNELS = 2;
   localparam int LATENCY = 3;
   localparam int COUNT_WIDTH = 2;
   localparam int IFW = $clog2(CHANNELS*LATENCY+1);

   typedef struct {
      int         due;
      logic [7:0] data;
   } expT;

   logic clk;
   logic reset;
   logic initialize;
   logic [CHANNELS*WIDTH-1:0] inData;
   logic [CHANNELS-1:0] inValid;
   logic [CHANNELS*WIDTH-1:0] outData;
   logic [CHANNELS-1:0] outValid;
   logic busy;
   logic [IFW-1:0] inFlight;
`ifdef NONBLOCKING_DELAY_CHANNEL_COUNTER_EN
   logic [COUNT_WIDTH-1:0] deliveredCount;
   int expCount = 0;
`endif

   int checkCount = 0;
   int errorCount = 0;
   int edgeIdx = -1;
   expT laneQ[CHANNELS][$];
   logic [7:0] lastDelivered[CHANNELS];

   nonblocking_delay_channel #(
      .WIDTH(WIDTH),
      .CHANNELS(CHANNELS),
      .LATENCY(LATENCY),
      .COUNT_WIDTH(COUNT_WIDTH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .initialize(initialize),
      .in_data(inData),
      .in_valid(inValid),
      .out_data(outData),
      .out_valid(outValid),
      .busy(busy),
      .in_flight(inFlight)
`ifdef NONBLOCKING_DELAY_CHANNEL_COUNTER_EN
      ,
      .delivered_count(deliveredCount)
`endif
   );

   // Free-running clock and an edge index shared by stimulus and monitor.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) edgeIdx <= edgeIdx + 1;

   // Every comparison funnels through here so the counts stay in one place.
   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at edge %0d", name, actual, expected, edgeIdx);
      end
   endtask

   // Drives one edge of inputs, then records what that edge should eventually deliver.
   task automatic applyStimulus(input logic [1:0] valid, input logic [7:0] d0, input logic [7:0] d1,
                                input logic init);
      expT e;
      inValid = valid;
      inData = {d1, d0};
      initialize = init;
      @(posedge clk);
      #1;
      if (init) begin
         for (int c = 0; c < CHANNELS; c++) laneQ[c].delete();
`ifdef NONBLOCKING_DELAY_CHANNEL_COUNTER_EN
         expCount = 0;
`endif
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (valid[c]) begin
               e.due = edgeIdx + LATENCY - 1;
               e.data = (c == 0) ? d0 : d1;
               laneQ[c].push_back(e);
            end
         end
      end
      inValid = '0;
      initialize = 1'b0;
   endtask

   // Monitor: compares the DUT against the scoreboard every cycle, away from the clock edge.
   always @(negedge clk) begin
      int expInFlight;
      int delivered;
      logic expValid;
      logic [7:0] expData;
      expInFlight = 0;
      delivered = 0;
      for (int c = 0; c < CHANNELS; c++) expInFlight += laneQ[c].size();
      checkOutput("in_flight", int'(inFlight), expInFlight);
      checkOutput("busy", int'(busy), int'(expInFlight != 0));
      for (int c = 0; c < CHANNELS; c++) begin
         expValid = 1'b0;
         expData = lastDelivered[c];
         if (laneQ[c].size() > 0 && laneQ[c][0].due == edgeIdx) begin
            expValid = 1'b1;
            expData = laneQ[c][0].data;
            void'(laneQ[c].pop_front());
            lastDelivered[c] = expData;
            delivered++;
         end
         checkOutput($sformatf("out_valid[%0d]", c), int'(outValid[c]), int'(expValid));
         checkOutput($sformatf("out_data[%0d]", c), int'(outData[c*WIDTH +: WIDTH]), int'(expData));
      end
`ifdef NONBLOCKING_DELAY_CHANNEL_COUNTER_EN
      checkOutput("delivered_count", int'(deliveredCount), expCount);
      expCount = (expCount + delivered > 3) ? 3 : expCount + delivered;
`endif
   end

   initial begin
      reset = 1'b1;
      initialize = 1'b0;
      inValid = '0;
      inData = '0;
      for (int c = 0; c < CHANNELS; c++) lastDelivered[c] = 8'h00;
      #1 reset = 1'b0;
      #1;
      checkOutput("reset out_valid", int'(outValid), 0);
      checkOutput("reset out_data", int'(outData), 0);
      checkOutput("reset in_flight", int'(inFlight), 0);
      repeat (2) @(negedge clk);
      #1 reset = 1'b1;

      $display("[TB] single message lane0");
      applyStimulus(2'b01, 8'hA5, 8'h3C, 1'b0);
      repeat (4) applyStimulus(2'b00, 8'h00, 8'h00, 1'b0);

      $display("[TB] back-to-back lane0");
      applyStimulus(2'b01, 8'h01, 8'h00, 1'b0);
      applyStimulus(2'b01, 8'h02, 8'h00, 1'b0);
      applyStimulus(2'b01, 8'h03, 8'h00, 1'b0);
      repeat (4) applyStimulus(2'b00, 8'h00, 8'h00, 1'b0);

      $display("[TB] data hold");
      applyStimulus(2'b01, 8'h5C, 8'h00, 1'b0);
      repeat (4) applyStimulus(2'b00, 8'hFF, 8'hFF, 1'b0);

      $display("[TB] mixed lanes");
      applyStimulus(2'b11, 8'h10, 8'h20, 1'b0);
      applyStimulus(2'b10, 8'h11, 8'h21, 1'b0);
      applyStimulus(2'b01, 8'h12, 8'h22, 1'b0);
      repeat (4) applyStimulus(2'b00, 8'h00, 8'h00, 1'b0);

      $display("[TB] initialize flush");
      applyStimulus(2'b01, 8'h77, 8'h00, 1'b0);
      applyStimulus(2'b10, 8'h00, 8'h88, 1'b0);
      applyStimulus(2'b11, 8'h99, 8'hAA, 1'b1);
      repeat (4) applyStimulus(2'b00, 8'h00, 8'h00, 1'b0);

      $display("[TB] dual-lane burst");
      applyStimulus(2'b11, 8'h01, 8'h02, 1'b0);
      applyStimulus(2'b11, 8'h03, 8'h04, 1'b0);
      applyStimulus(2'b11, 8'h05, 8'h06, 1'b0);
      repeat (5) applyStimulus(2'b00, 8'h00, 8'h00, 1'b0);
      applyStimulus(2'b00, 8'h00, 8'h00, 1'b1);
      repeat (2) applyStimulus(2'b00, 8'h00, 8'h00, 1'b0);

      $display("[TB] async reset mid-flight");
      applyStimulus(2'b11, 8'hE1, 8'hE2, 1'b0);
      applyStimulus(2'b11, 8'hE3, 8'hE4, 1'b0);
      #2;
      for (int c = 0; c < CHANNELS; c++) begin
         laneQ[c].delete();
         lastDelivered[c] = 8'h00;
      end
`ifdef NONBLOCKING_DELAY_CHANNEL_COUNTER_EN
      expCount = 0;
`endif
      reset = 1'b0;
      #1;
      checkOutput("async out_valid", int'(outValid), 0);
      checkOutput("async out_data", int'(outData), 0);
      checkOutput("async in_flight", int'(inFlight), 0);
      checkOutput("async busy", int'(busy), 0);
      @(negedge clk);
      #1 reset = 1'b1;

      applyStimulus(2'b01, 8'h42, 8'h00, 1'b0);
      repeat (4) applyStimulus(2'b00, 8'h00, 8'h00, 1'b0);

      @(negedge clk);
      #1;
      for (int c = 0; c < CHANNELS; c++) checkOutput($sformatf("drained lane%0d", c), laneQ[c].size(), 0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/nonblocking_delay_channel.md
Name: nonblocking_delay_channel

Overview:
Multi-lane, fixed-latency nonblocking message channel for decoder mesh links between processing units. Each of CHANNELS independent lanes carries WIDTH-bit messages through a LATENCY-deep register pipeline. There is no backpressure: a message presented with valid is always accepted and always delivered exactly LATENCY cycles later. Lane valids are flushed by a synchronous initialize, used between decoding rounds. Adds busy and in-flight occupancy outputs for round-completion detection.

Parameters:
WIDTH, 8, message width per lane in bits (>=1)
CHANNELS, 1, number of independent lanes (>=1)
LATENCY, 1, pipeline depth in cycles from input edge to output (>=1)
COUNT_WIDTH, 16, width of delivered-message counter (optional feature only)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
initialize  input  1  synchronous flush of all in-flight messages, active-high
in_data  input  CHANNELS*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  CHANNELS  bit i qualifies lane i of in_data
out_data  output  CHANNELS*WIDTH  delayed lane data, same packing as in_data
out_valid  output  CHANNELS  delayed lane valid
busy  output  1  high when any stage of any lane holds a valid message
in_flight  output  $clog2(CHANNELS*LATENCY+1)  number of valid messages currently held in all stages

Behaviour:
- Per lane: LATENCY stages, each a valid bit plus WIDTH data register; stage LATENCY-1 drives out_valid/out_data.
- Reset (reset==0, asynchronous): all stage valids 0, all stage data 0; out_valid=0, out_data=0, busy=0, in_flight=0; counter 0. Deassertion takes effect at the next edge.
- Initialize (reset==1, initialize==1 at edge): all stage valids cleared; input on that edge discarded; data registers hold their values. out_valid=0 from the following cycle.
- Normal edge: stage 0 valid <= in_valid[i]; stage k valid <= stage k-1 valid.
- Data gating: a stage's data register loads only when its incoming valid is 1; otherwise it holds. out_data therefore holds the last delivered message of that lane while out_valid=0.
- Latency: message sampled at edge n is visible on out_* after edge n+LATENCY-1 (i.e. during cycle n+LATENCY), exactly LATENCY edges of delay, independent of other lanes or back-to-back traffic.
- Throughput: one message per lane per cycle; consecutive messages never merge or drop.
- Lanes fully independent; no ordering relation across lanes.
- busy = OR of all stage valids (combinational from registers, no extra latency).
- in_flight = popcount of all stage valids across all lanes; max CHANNELS*LATENCY; never wraps.
- Simultaneous initialize with in_valid: initialize wins, message lost. Reset overrides initialize.
- Reset mid-operation: all in-flight messages lost immediately; no partial outputs.
- LATENCY==1 behaves as single-register channel per lane, with data gating as above.

Optional Feature:
Macro NONBLOCKING_DELAY_CHANNEL_COUNTER_EN.
- Defined: adds output delivered_count (COUNT_WIDTH) = total number of out_valid bits seen high across all lanes since last reset/initialize; adds popcount(out_valid) each edge; saturates at all-ones (no wrap); cleared to 0 by reset and by initialize (initialize edge counts nothing).
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- CHANNELS=2, LATENCY=3: lane0 in_valid=1, data 0xA5 at edge 0 -> out_valid[0]=1, out_data lane0=0xA5 after edge 2 only, for one cycle; lane1 stays invalid; in_flight=1 for cycles 1..3.
- Back-to-back: lane0 sends 0x01,0x02,0x03 on edges 0,1,2 -> outputs 0x01,0x02,0x03 on consecutive cycles after edges 2,3,4; in_flight peaks at 3, busy=1 throughout, then 0.
- Data hold: send 0x5C once, then in_valid=0 with in_data=0xFF -> after delivery out_valid=0, out_data stays 0x5C.
- Initialize flush: two messages in flight (in_flight=2), assert initialize with in_valid=1 -> next cycle in_flight=0, busy=0, no message ever emerges.
- Async reset: drop reset to 0 between edges with messages in flight -> out_valid=0, out_data=0, in_flight=0 immediately, before any clock edge.
- COUNTER_EN, COUNT_WIDTH=2, CHANNELS=2: deliver 2 messages/cycle for 3 cycles -> delivered_count 2, then 3, 3 (saturated); initialize -> 0.
